rtl_vec_alu_acc: RTL and testbench
==================================

Name: rtl_vec_alu_acc

Overview:
- Parametrised successor of the single-shot vector-add accelerator.
- Reads two N-element 64-bit vectors A and B over the DMA read interface from a configurable base index, and applies a selectable element-wise op with UNROLL lanes per cycle.
- Writes the N-element result to a configurable write base index.
- N, the op and both base indices are runtime configuration.
- Sits behind the ESP accelerator socket (conf/DMA/acc_done interface).

Parameters:
- MAX_LEN, 64, maximum elements per vector; buffer depth for A, B and C.
- UNROLL, 4, elements computed per COMPUTE cycle; must divide MAX_LEN.
- DATA_W, 64, element and beat width; only 64 is supported (DMA beat width).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- conf_info_reg0  in  32  read base index (beats)
- conf_info_reg1  in  32  [15:0] vector length N; [17:16] op: 00 add, 01 sub (A-B), 10 xor, 11 unsigned max
- conf_info_reg2  in  32  write base index (beats)
- conf_done  in  1  one-cycle pulse, configuration valid
- acc_done  out  1  one-cycle pulse, task finished
- debug  out  32  {err, 28'd0, state[2:0]}
- dma_read_ctrl_ready  in  1
- dma_read_ctrl_valid  out  1
- dma_read_ctrl_data_index  out  32
- dma_read_ctrl_data_length  out  32
- dma_read_ctrl_data_size  out  3
- dma_read_ctrl_data_user  out  6
- dma_read_chnl_ready  out  1
- dma_read_chnl_valid  in  1
- dma_read_chnl_data  in  64
- dma_write_ctrl_ready  in  1
- dma_write_ctrl_valid  out  1
- dma_write_ctrl_data_index  out  32
- dma_write_ctrl_data_length  out  32
- dma_write_ctrl_data_size  out  3
- dma_write_ctrl_data_user  out  6
- dma_write_chnl_ready  in  1
- dma_write_chnl_valid  out  1
- dma_write_chnl_data  out  64

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE; all valid/ready outputs, acc_done and err are 0.
  - Ctrl index/length/size/user outputs, pointers and the chunk counter are 0.
  - Buffer contents are not reset.
  - Reset mid-transfer aborts immediately; no acc_done is generated.
- States: IDLE(0), RD_REQ(1), RD_DATA(2), COMPUTE(3), WR_REQ(4), WR_DATA(5), DONE(6).
- IDLE:
  - On conf_done, latch reg0/reg1/reg2 and clear err.
  - If N==0 or N>MAX_LEN: set err=1 and go to DONE; no DMA activity occurs.
  - Otherwise go to RD_REQ and drive read ctrl: index=reg0, length=2N, size=3'b011, user=0.
  - conf_done outside IDLE is ignored.
- RD_REQ:
  - dma_read_ctrl_valid=1, held with stable fields until dma_read_ctrl_ready.
  - On the handshake: valid<=0, dma_read_chnl_ready<=1, go to RD_DATA.
- RD_DATA:
  - Each chnl handshake stores beat k; k<N goes to A[k], otherwise B[k-N]; k increments.
  - When the handshake with k==2N-1 occurs: chnl_ready<=0 and go to COMPUTE.
  - chnl_valid while ready=0 is ignored.
- COMPUTE:
  - Each cycle processes elements c*UNROLL..c*UNROLL+UNROLL-1 into C; lanes with index>=N are left unwritten.
  - The op is 64-bit modulo 2^64; sub wraps; max is an unsigned compare.
  - Takes exactly ceil(N/UNROLL) cycles, then goes to WR_REQ with write ctrl fields: index=reg2, length=N, size=3'b011, user=0.
- WR_REQ:
  - dma_write_ctrl_valid=1, held until ready.
  - On the handshake: valid<=0, chnl_valid<=1, go to WR_DATA.
- WR_DATA:
  - dma_write_chnl_data = C[rd_ptr], combinational from rd_ptr.
  - valid and data are held stable while ready=0.
  - Each handshake increments rd_ptr.
  - On the handshake with rd_ptr==N-1: valid<=0 and go to DONE.
  - The write channel is never valid before the write ctrl handshake.
- DONE:
  - acc_done=1 for exactly one cycle, then IDLE.
  - err remains visible in debug[31] until the next conf_done.
- Pointers reset to 0 on every IDLE exit.
- Back-to-back tasks are allowed: conf_done in the cycle after acc_done is accepted.

Test Plan:
- N=4, op=add, reg0=0, reg2=8, A={1,2,3,4}, B={10,20,30,40} -> read req index 0 length 8; write req index 8 length 4; data {11,22,33,44}; one acc_done pulse.
- N=5, UNROLL=4, op=sub, A=0, B=1 in every element -> COMPUTE lasts 2 cycles; all outputs 0xFFFF_FFFF_FFFF_FFFF.
- N=MAX_LEN, op=max, random data, dma_write_chnl_ready toggling 1/0 every cycle -> 64 beats match the model; data stable across stalls; no lost or duplicated beats.
- N=0, then N=65 -> no DMA ctrl valid ever asserted; acc_done pulses; debug[31]=1 in both cases.
- Reset asserted mid RD_DATA after 3 beats, then a new task with N=2 and op=xor -> no acc_done for the aborted task; second task correct (A^B).
- conf_done pulsed during COMPUTE, plus a ctrl_ready delay of 5 cycles on both ctrls -> extra conf_done ignored; ctrl fields held stable for all 6 valid cycles.

Source files
------------

// File: rtl/rtl_vec_alu_acc_if.sv
// DMA read/write control and channel bundle between the vector ALU accelerator and the ESP socket.
// The master side is the accelerator; the slave side is the DMA engine.
interface rtl_vec_alu_acc_if #(
    parameter int DATA_W = 64
);
    logic              read_ctrl_ready;
    logic              read_ctrl_valid;
    logic [31:0]       read_ctrl_data_index;
    logic [31:0]       read_ctrl_data_length;
    logic [2:0]        read_ctrl_data_size;
    logic [5:0]        read_ctrl_data_user;
    logic              read_chnl_ready;
    logic              read_chnl_valid;
    logic [DATA_W-1:0] read_chnl_data;

    logic              write_ctrl_ready;
    logic              write_ctrl_valid;
    logic [31:0]       write_ctrl_data_index;
    logic [31:0]       write_ctrl_data_length;
    logic [2:0]        write_ctrl_data_size;
    logic [5:0]        write_ctrl_data_user;
    logic              write_chnl_ready;
    logic              write_chnl_valid;
    logic [DATA_W-1:0] write_chnl_data;

    modport master (
        input  read_ctrl_ready,
        output read_ctrl_valid, read_ctrl_data_index, read_ctrl_data_length,
        output read_ctrl_data_size, read_ctrl_data_user,
        output read_chnl_ready,
        input  read_chnl_valid, read_chnl_data,
        input  write_ctrl_ready,
        output write_ctrl_valid, write_ctrl_data_index, write_ctrl_data_length,
        output write_ctrl_data_size, write_ctrl_data_user,
        input  write_chnl_ready,
        output write_chnl_valid, write_chnl_data
    );

    modport slave (
        output read_ctrl_ready,
        input  read_ctrl_valid, read_ctrl_data_index, read_ctrl_data_length,
        input  read_ctrl_data_size, read_ctrl_data_user,
        input  read_chnl_ready,
        output read_chnl_valid, read_chnl_data,
        output write_ctrl_ready,
        input  write_ctrl_valid, write_ctrl_data_index, write_ctrl_data_length,
        input  write_ctrl_data_size, write_ctrl_data_user,
        output write_chnl_ready,
        input  write_chnl_valid, write_chnl_data
    );
endinterface

// File: rtl/rtl_vec_alu_acc.sv
// Vector ALU accelerator: DMA-reads A and B, applies add/sub/xor/umax over UNROLL lanes per
// cycle, and DMA-writes the result vector C.
module rtl_vec_alu_acc #(
    parameter int MAX_LEN = 64,
    parameter int UNROLL  = 4,
    parameter int DATA_W  = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          conf_info_reg0,
    input  logic [31:0]          conf_info_reg1,
    input  logic [31:0]          conf_info_reg2,
    input  logic                 conf_done,
    output logic                 acc_done,
    output logic [31:0]          debug,
    rtl_vec_alu_acc_if.master    dma
);
    localparam int          IDX_W = $clog2(MAX_LEN);
    localparam logic [15:0] UNR   = 16'(UNROLL);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_DATA = 3'd2,
        COMPUTE = 3'd3,
        WR_REQ  = 3'd4,
        WR_DATA = 3'd5,
        DONE    = 3'd6
    } state_t;

    state_t      state, state_nxt;
    logic        err;
    logic [15:0] len_q;
    logic [1:0]  op_q;
    logic [31:0] wbase_q;
    logic [15:0] beat_cnt;
    logic [15:0] chunk_cnt;
    logic [15:0] rd_ptr;

    logic [DATA_W-1:0] a_mem [MAX_LEN];
    logic [DATA_W-1:0] b_mem [MAX_LEN];
    logic [DATA_W-1:0] c_mem [MAX_LEN];

    logic [15:0]      cfg_len;
    logic             cfg_bad;
    logic             rd_ctrl_hs, rd_chnl_hs, wr_ctrl_hs, wr_chnl_hs;
    logic             last_beat, last_chunk, last_wr;
    logic [15:0]      lane_base;
    logic [15:0]      b_off;
    logic [15:0]      lane_full [UNROLL];
    logic [IDX_W-1:0] lane_idx  [UNROLL];
    logic             lane_vld  [UNROLL];
    logic             unused_cfg;

    function automatic logic [DATA_W-1:0] alu_op(input logic [1:0] op,
                                                 input logic [DATA_W-1:0] a,
                                                 input logic [DATA_W-1:0] b);
        case (op)
            2'b00:   alu_op = a + b;
            2'b01:   alu_op = a - b;
            2'b10:   alu_op = a ^ b;
            default: alu_op = (a > b) ? a : b;
        endcase
    endfunction

    assign cfg_len    = conf_info_reg1[15:0];
    assign cfg_bad    = (cfg_len == 16'd0) || (cfg_len > 16'(MAX_LEN));
    assign unused_cfg = ^conf_info_reg1[31:18];

    assign rd_ctrl_hs = dma.read_ctrl_valid  && dma.read_ctrl_ready;
    assign rd_chnl_hs = dma.read_chnl_valid  && dma.read_chnl_ready;
    assign wr_ctrl_hs = dma.write_ctrl_valid && dma.write_ctrl_ready;
    assign wr_chnl_hs = dma.write_chnl_valid && dma.write_chnl_ready;

    assign last_beat  = beat_cnt == ((len_q << 1) - 16'd1);
    assign lane_base  = chunk_cnt * UNR;
    assign last_chunk = (lane_base + UNR) >= len_q;
    assign last_wr    = rd_ptr == (len_q - 16'd1);
    assign b_off      = beat_cnt - len_q;

    always_comb begin
        for (int l = 0; l < UNROLL; l++) begin
            lane_full[l] = lane_base + 16'(l);
            lane_vld[l]  = lane_full[l] < len_q;
            lane_idx[l]  = lane_full[l][IDX_W-1:0];
        end
    end

    assign dma.write_chnl_data = c_mem[rd_ptr[IDX_W-1:0]];
    assign debug               = {err, 28'd0, state};

    always_comb begin
        state_nxt = state;
        acc_done  = 1'b0;
        case (state)
            IDLE:    if (conf_done) state_nxt = cfg_bad ? DONE : RD_REQ;
            RD_REQ:  if (rd_ctrl_hs) state_nxt = RD_DATA;
            RD_DATA: if (rd_chnl_hs && last_beat) state_nxt = COMPUTE;
            COMPUTE: if (last_chunk) state_nxt = WR_REQ;
            WR_REQ:  if (wr_ctrl_hs) state_nxt = WR_DATA;
            WR_DATA: if (wr_chnl_hs && last_wr) state_nxt = DONE;
            DONE: begin
                acc_done  = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state                      <= IDLE;
            err                        <= 1'b0;
            len_q                      <= '0;
            op_q                       <= '0;
            wbase_q                    <= '0;
            beat_cnt                   <= '0;
            chunk_cnt                  <= '0;
            rd_ptr                     <= '0;
            dma.read_ctrl_valid        <= 1'b0;
            dma.read_ctrl_data_index   <= '0;
            dma.read_ctrl_data_length  <= '0;
            dma.read_ctrl_data_size    <= '0;
            dma.read_ctrl_data_user    <= '0;
            dma.read_chnl_ready        <= 1'b0;
            dma.write_ctrl_valid       <= 1'b0;
            dma.write_ctrl_data_index  <= '0;
            dma.write_ctrl_data_length <= '0;
            dma.write_ctrl_data_size   <= '0;
            dma.write_ctrl_data_user   <= '0;
            dma.write_chnl_valid       <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: if (conf_done) begin
                    len_q     <= cfg_len;
                    op_q      <= conf_info_reg1[17:16];
                    wbase_q   <= conf_info_reg2;
                    err       <= cfg_bad;
                    beat_cnt  <= '0;
                    chunk_cnt <= '0;
                    rd_ptr    <= '0;
                    if (!cfg_bad) begin
                        dma.read_ctrl_valid       <= 1'b1;
                        dma.read_ctrl_data_index  <= conf_info_reg0;
                        dma.read_ctrl_data_length <= {15'd0, cfg_len, 1'b0};
                        dma.read_ctrl_data_size   <= 3'b011;
                        dma.read_ctrl_data_user   <= 6'd0;
                    end
                end
                RD_REQ: if (rd_ctrl_hs) begin
                    dma.read_ctrl_valid <= 1'b0;
                    dma.read_chnl_ready <= 1'b1;
                end
                RD_DATA: if (rd_chnl_hs) begin
                    beat_cnt <= beat_cnt + 16'd1;
                    if (last_beat) dma.read_chnl_ready <= 1'b0;
                end
                COMPUTE: begin
                    chunk_cnt <= chunk_cnt + 16'd1;
                    if (last_chunk) begin
                        dma.write_ctrl_valid       <= 1'b1;
                        dma.write_ctrl_data_index  <= wbase_q;
                        dma.write_ctrl_data_length <= {16'd0, len_q};
                        dma.write_ctrl_data_size   <= 3'b011;
                        dma.write_ctrl_data_user   <= 6'd0;
                    end
                end
                WR_REQ: if (wr_ctrl_hs) begin
                    dma.write_ctrl_valid <= 1'b0;
                    dma.write_chnl_valid <= 1'b1;
                end
                WR_DATA: if (wr_chnl_hs) begin
                    rd_ptr <= rd_ptr + 16'd1;
                    if (last_wr) dma.write_chnl_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Buffers carry no reset; beats land in A for k<N, then in B.
    always_ff @(posedge clk) begin
        if (state == RD_DATA && rd_chnl_hs) begin
            if (beat_cnt < len_q) a_mem[beat_cnt[IDX_W-1:0]] <= dma.read_chnl_data;
            else                  b_mem[b_off[IDX_W-1:0]]    <= dma.read_chnl_data;
        end
        if (state == COMPUTE) begin
            for (int l = 0; l < UNROLL; l++) begin
                if (lane_vld[l])
                    c_mem[lane_idx[l]] <= alu_op(op_q, a_mem[lane_idx[l]], b_mem[lane_idx[l]]);
            end
        end
    end
endmodule

// File: tb/tb_rtl_vec_alu_acc.sv
// Bench for rtl_vec_alu_acc: a DMA-side driver issues tasks and queues expected result beats;
// an independent monitor pops and compares every write-channel beat.
module tb_rtl_vec_alu_acc;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] conf0, conf1, conf2;
    logic        conf_done;
    logic        acc_done;
    logic [31:0] debug;

    always #5 clk = ~clk;

    rtl_vec_alu_acc_if #(.DATA_W(64)) dma ();

    rtl_vec_alu_acc #(.MAX_LEN(64), .UNROLL(4), .DATA_W(64)) dut (
        .clk            (clk),
        .rst            (rst),
        .conf_info_reg0 (conf0),
        .conf_info_reg1 (conf1),
        .conf_info_reg2 (conf2),
        .conf_done      (conf_done),
        .acc_done       (acc_done),
        .debug          (debug),
        .dma            (dma)
    );

    int          n_vec = 0;
    int          n_err = 0;
    logic [63:0] exp_q [$];
    logic [63:0] va [64];
    logic [63:0] vb [64];
    logic [63:0] ve [64];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor on the write channel
    logic        wr_hs_seen = 1'b0;
    logic        prev_stall = 1'b0;
    logic [63:0] prev_data  = '0;

    always @(negedge clk) begin
        if (rst) begin
            wr_hs_seen <= 1'b0;
            prev_stall <= 1'b0;
        end else begin
            if (dma.write_ctrl_valid && dma.write_ctrl_ready) wr_hs_seen <= 1'b1;
            else if (debug[2:0] == 3'd0)                      wr_hs_seen <= 1'b0;
            if (dma.write_chnl_valid) chk("wchnl_after_ctrl", {63'd0, wr_hs_seen}, 64'd1);
            if (prev_stall) begin
                chk("wchnl_valid_held", {63'd0, dma.write_chnl_valid}, 64'd1);
                chk("wchnl_data_held", dma.write_chnl_data, prev_data);
            end
            if (dma.write_chnl_valid && dma.write_chnl_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL wdata_extra: got %h, expected no beat", dma.write_chnl_data);
                end else begin
                    chk("wdata", dma.write_chnl_data, exp_q.pop_front());
                end
            end
            prev_stall <= dma.write_chnl_valid && !dma.write_chnl_ready;
            prev_data  <= dma.write_chnl_data;
        end
    end

    task automatic run_task(input logic [31:0] rb, input int n, input logic [1:0] op,
                            input logic [31:0] wb, input int cdly, input bit wtoggle,
                            input bit conf_in_compute, input int abort_after);
        int cnt;
        int cyc;
        int got;
        for (int i = 0; i < n; i++) exp_q.push_back(ve[i]);
        conf0     = rb;
        conf1     = {14'd0, op, 16'(n)};
        conf2     = wb;
        conf_done = 1'b1;
        tick();
        conf_done = 1'b0;

        cnt = 0;
        while (!dma.read_ctrl_valid && cnt < 20) begin tick(); cnt++; end
        for (int i = 0; i <= cdly; i++) begin
            dma.read_ctrl_ready = (i == cdly);
            chk("rd_ctrl_valid", {63'd0, dma.read_ctrl_valid}, 64'd1);
            chk("rd_index", 64'(dma.read_ctrl_data_index), 64'(rb));
            chk("rd_length", 64'(dma.read_ctrl_data_length), 64'(2 * n));
            chk("rd_size", 64'(dma.read_ctrl_data_size), 64'd3);
            chk("rd_user", 64'(dma.read_ctrl_data_user), 64'd0);
            tick();
        end
        dma.read_ctrl_ready = 1'b0;
        chk("rd_ctrl_drop", {63'd0, dma.read_ctrl_valid}, 64'd0);

        for (int k = 0; k < 2 * n; k++) begin
            if (k == abort_after) begin
                rst = 1'b1;
                tick();
                rst = 1'b0;
                dma.read_chnl_valid = 1'b0;
                exp_q.delete();
                return;
            end
            dma.read_chnl_data  = (k < n) ? va[k] : vb[k-n];
            dma.read_chnl_valid = 1'b1;
            cnt = 0;
            while (!dma.read_chnl_ready && cnt < 20) begin tick(); cnt++; end
            if (cnt >= 20) chk("rd_chnl_ready", {63'd0, dma.read_chnl_ready}, 64'd1);
            tick();
        end
        dma.read_chnl_valid = 1'b0;

        cyc = 0;
        while (debug[2:0] == 3'd3 && cyc < 100) begin
            if (conf_in_compute && cyc == 0) begin
                conf0     = 32'h0000_DEAD;
                conf1     = {14'd0, 2'b00, 16'd1};
                conf2     = 32'h0000_BEEF;
                conf_done = 1'b1;
            end
            tick();
            conf_done = 1'b0;
            cyc++;
        end
        chk("compute_cycles", 64'(cyc), 64'((n + 3) / 4));

        cnt = 0;
        while (!dma.write_ctrl_valid && cnt < 20) begin tick(); cnt++; end
        for (int i = 0; i <= cdly; i++) begin
            dma.write_ctrl_ready = (i == cdly);
            chk("wr_ctrl_valid", {63'd0, dma.write_ctrl_valid}, 64'd1);
            chk("wr_index", 64'(dma.write_ctrl_data_index), 64'(wb));
            chk("wr_length", 64'(dma.write_ctrl_data_length), 64'(n));
            chk("wr_size", 64'(dma.write_ctrl_data_size), 64'd3);
            chk("wr_user", 64'(dma.write_ctrl_data_user), 64'd0);
            tick();
        end
        dma.write_ctrl_ready = 1'b0;

        got = 0;
        cyc = 0;
        while (got < n && cyc < 1000) begin
            dma.write_chnl_ready = wtoggle ? (cyc % 2 == 0) : 1'b1;
            if (dma.write_chnl_valid && dma.write_chnl_ready) got++;
            tick();
            cyc++;
        end
        dma.write_chnl_ready = 1'b0;
        chk("wr_beats", 64'(got), 64'(n));
        chk("acc_done", {63'd0, acc_done}, 64'd1);
        chk("done_state", 64'(debug[2:0]), 64'd6);
        chk("err_clear", {63'd0, debug[31]}, 64'd0);
        tick();
        chk("acc_done_pulse", {63'd0, acc_done}, 64'd0);
        chk("idle_state", 64'(debug[2:0]), 64'd0);
    endtask

    task automatic err_task(input int n);
        conf0     = 32'd0;
        conf1     = {14'd0, 2'b00, 16'(n)};
        conf2     = 32'd0;
        conf_done = 1'b1;
        tick();
        conf_done = 1'b0;
        chk("err_acc_done", {63'd0, acc_done}, 64'd1);
        chk("err_flag", {63'd0, debug[31]}, 64'd1);
        chk("err_no_rd_ctrl", {63'd0, dma.read_ctrl_valid}, 64'd0);
        chk("err_no_wr_ctrl", {63'd0, dma.write_ctrl_valid}, 64'd0);
        tick();
        chk("err_acc_done_pulse", {63'd0, acc_done}, 64'd0);
        chk("err_flag_sticky", {63'd0, debug[31]}, 64'd1);
        chk("err_no_rd_ctrl2", {63'd0, dma.read_ctrl_valid}, 64'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst                  = 1'b1;
        conf0                = '0;
        conf1                = '0;
        conf2                = '0;
        conf_done            = 1'b0;
        dma.read_ctrl_ready  = 1'b0;
        dma.read_chnl_valid  = 1'b0;
        dma.read_chnl_data   = '0;
        dma.write_ctrl_ready = 1'b0;
        dma.write_chnl_ready = 1'b0;
        tick();
        tick();
        chk("rst_debug", 64'(debug), 64'd0);
        chk("rst_acc_done", {63'd0, acc_done}, 64'd0);
        chk("rst_rd_valid", {63'd0, dma.read_ctrl_valid}, 64'd0);
        chk("rst_rd_index", 64'(dma.read_ctrl_data_index), 64'd0);
        chk("rst_rd_chnl_ready", {63'd0, dma.read_chnl_ready}, 64'd0);
        chk("rst_wr_valid", {63'd0, dma.write_ctrl_valid}, 64'd0);
        chk("rst_wr_chnl_valid", {63'd0, dma.write_chnl_valid}, 64'd0);
        rst = 1'b0;
        tick();

        // N=4 add
        va[0] = 64'd1;  va[1] = 64'd2;  va[2] = 64'd3;  va[3] = 64'd4;
        vb[0] = 64'd10; vb[1] = 64'd20; vb[2] = 64'd30; vb[3] = 64'd40;
        ve[0] = 64'd11; ve[1] = 64'd22; ve[2] = 64'd33; ve[3] = 64'd44;
        run_task(32'd0, 4, 2'b00, 32'd8, 0, 1'b0, 1'b0, -1);

        // N=5 sub 0-1, issued the cycle after acc_done
        for (int i = 0; i < 5; i++) begin
            va[i] = 64'd0;
            vb[i] = 64'd1;
            ve[i] = 64'hFFFF_FFFF_FFFF_FFFF;
        end
        run_task(32'd3, 5, 2'b01, 32'd100, 0, 1'b0, 1'b0, -1);

        // N=64 unsigned max with toggling write ready
        for (int i = 0; i < 64; i++) begin
            va[i] = {$urandom(), $urandom()};
            vb[i] = {$urandom(), $urandom()};
        end
        va[0] = 64'hFFFF_FFFF_FFFF_FFFF; vb[0] = 64'd0;
        va[1] = 64'd0;                   vb[1] = 64'h8000_0000_0000_0000;
        va[2] = 64'd7;                   vb[2] = 64'd7;
        for (int i = 0; i < 64; i++) ve[i] = (va[i] > vb[i]) ? va[i] : vb[i];
        run_task(32'd40, 64, 2'b11, 32'd200, 0, 1'b1, 1'b0, -1);

        err_task(0);
        err_task(65);

        // Reset after 3 read beats, then N=2 xor
        run_task(32'd0, 4, 2'b00, 32'd8, 0, 1'b0, 1'b0, 3);
        for (int i = 0; i < 5; i++) begin
            chk("abort_no_acc_done", {63'd0, acc_done}, 64'd0);
            chk("abort_idle", 64'(debug[2:0]), 64'd0);
            tick();
        end
        va[0] = 64'd5;     vb[0] = 64'd3;     ve[0] = 64'd6;
        va[1] = 64'hFF00;  vb[1] = 64'h0FF0;  ve[1] = 64'hF0F0;
        run_task(32'd12, 2, 2'b10, 32'd20, 0, 1'b0, 1'b0, -1);

        // conf_done during COMPUTE, ctrl ready delayed 5 cycles
        va[0] = 64'd100; va[1] = 64'd200; va[2] = 64'hFFFF_FFFF_FFFF_FFFF; va[3] = 64'd0;
        vb[0] = 64'd1;   vb[1] = 64'd2;   vb[2] = 64'd2;                   vb[3] = 64'd0;
        ve[0] = 64'd101; ve[1] = 64'd202; ve[2] = 64'd1;                   ve[3] = 64'd0;
        run_task(32'd16, 4, 2'b00, 32'd32, 5, 1'b0, 1'b1, -1);
        for (int i = 0; i < 4; i++) begin
            chk("ignored_conf_idle", 64'(debug[2:0]), 64'd0);
            tick();
        end

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
